// File: rtl/decode_if.sv
// Handshake and operand bundle between fetch, writeback, the decode stage and execute.
// The slave modport is the decode stage's view; master is the surrounding pipeline.
interface decode_if #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
);
  logic                      instr_valid_in;
  logic [31:0]               instr_in;
  logic                      instr_ready_out;
  logic                      wb_en_in;
  logic [REG_ADDR_WIDTH-1:0] wb_addr_in;
  logic [DATA_WIDTH-1:0]     wb_data_in;
  logic                      ex_valid_out;
  logic                      ex_ready_in;
  logic [6:0]                opcode_out;
  logic [2:0]                funct3_out;
  logic [6:0]                funct7_out;
  logic [DATA_WIDTH-1:0]     rs1_value_out;
  logic [DATA_WIDTH-1:0]     mux_result_out;
  logic [REG_ADDR_WIDTH-1:0] rd_addr_out;
  logic                      illegal_out;

  modport slave (
    input  instr_valid_in, instr_in, wb_en_in, wb_addr_in, wb_data_in, ex_ready_in,
    output instr_ready_out, ex_valid_out, opcode_out, funct3_out, funct7_out,
           rs1_value_out, mux_result_out, rd_addr_out, illegal_out
  );

  modport master (
    output instr_valid_in, instr_in, wb_en_in, wb_addr_in, wb_data_in, ex_ready_in,
    input  instr_ready_out, ex_valid_out, opcode_out, funct3_out, funct7_out,
           rs1_value_out, mux_result_out, rd_addr_out, illegal_out
  );
endinterface

// File: rtl/decode_stage.sv
// RV32 integer decode stage: register file with writeback bypass, OP/OP-IMM operand
// selection and legality check, and a single valid/ready output register.
module decode_stage #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input logic     clk_in,
  input logic     rst_in,
  decode_if.slave bus
);
  localparam int NUM_REGS = 2 ** REG_ADDR_WIDTH;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] F7_ZERO    = 7'b0000000;
  localparam logic [6:0] F7_ALT     = 7'b0100000;

  typedef logic [DATA_WIDTH-1:0] word_t;

  word_t rf_q [NUM_REGS];
  word_t rf_d [NUM_REGS];

  logic                      ex_valid_q, ex_valid_d;
  logic [6:0]                opcode_q, opcode_d;
  logic [2:0]                funct3_q, funct3_d;
  logic [6:0]                funct7_q, funct7_d;
  word_t                     rs1_value_q, rs1_value_d;
  word_t                     mux_result_q, mux_result_d;
  logic [REG_ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic                      illegal_q, illegal_d;

  logic                      ready_s;
  logic                      accept_s;
  logic [6:0]                dec_opcode_s;
  logic [2:0]                dec_funct3_s;
  logic [6:0]                dec_funct7_raw_s;
  logic [REG_ADDR_WIDTH-1:0] rs1_idx_s, rs2_idx_s;
  word_t                     rs1_val_s, rs2_val_s;
  logic [6:0]                dec_funct7_s;
  word_t                     dec_mux_s;
  logic                      dec_illegal_s;

  assign ready_s          = !ex_valid_q || bus.ex_ready_in;
  assign accept_s         = bus.instr_valid_in && ready_s;
  assign dec_opcode_s     = bus.instr_in[6:0];
  assign dec_funct3_s     = bus.instr_in[14:12];
  assign dec_funct7_raw_s = bus.instr_in[31:25];
  assign rs1_idx_s        = bus.instr_in[15 +: REG_ADDR_WIDTH];
  assign rs2_idx_s        = bus.instr_in[20 +: REG_ADDR_WIDTH];

  // Operand read with same-cycle writeback bypass; x0 is hardwired to zero.
  always_comb begin
    rs1_val_s = rf_q[rs1_idx_s];
    rs2_val_s = rf_q[rs2_idx_s];
    if (rs1_idx_s == '0) begin
      rs1_val_s = '0;
    end else if (bus.wb_en_in && (bus.wb_addr_in == rs1_idx_s)) begin
      rs1_val_s = bus.wb_data_in;
    end else begin
      rs1_val_s = rf_q[rs1_idx_s];
    end
    if (rs2_idx_s == '0) begin
      rs2_val_s = '0;
    end else if (bus.wb_en_in && (bus.wb_addr_in == rs2_idx_s)) begin
      rs2_val_s = bus.wb_data_in;
    end else begin
      rs2_val_s = rf_q[rs2_idx_s];
    end
  end

  always_comb begin
    dec_funct7_s  = 7'd0;
    dec_mux_s     = '0;
    dec_illegal_s = 1'b1;
    case (dec_opcode_s)
      OPC_OP_IMM: begin
        if ((dec_funct3_s == 3'b001) || (dec_funct3_s == 3'b101)) begin
          dec_funct7_s  = dec_funct7_raw_s;
          dec_mux_s     = {{(DATA_WIDTH-5){1'b0}}, bus.instr_in[24:20]};
          dec_illegal_s = !((dec_funct7_raw_s == F7_ZERO) ||
                            ((dec_funct7_raw_s == F7_ALT) && (dec_funct3_s == 3'b101)));
        end else begin
          dec_funct7_s  = 7'd0;
          dec_mux_s     = {{(DATA_WIDTH-12){bus.instr_in[31]}}, bus.instr_in[31:20]};
          dec_illegal_s = 1'b0;
        end
      end
      OPC_OP: begin
        dec_funct7_s  = dec_funct7_raw_s;
        dec_mux_s     = rs2_val_s;
        dec_illegal_s = !((dec_funct7_raw_s == F7_ZERO) ||
                          ((dec_funct7_raw_s == F7_ALT) &&
                           ((dec_funct3_s == 3'b000) || (dec_funct3_s == 3'b101))));
      end
      default: begin
        dec_funct7_s  = 7'd0;
        dec_mux_s     = '0;
        dec_illegal_s = 1'b1;
      end
    endcase
  end

  // Next state: the bundle holds unless a new instruction is accepted.
  always_comb begin
    rf_d = rf_q;
    if (bus.wb_en_in && (bus.wb_addr_in != '0)) begin
      rf_d[bus.wb_addr_in] = bus.wb_data_in;
    end else begin
      rf_d = rf_q;
    end
    ex_valid_d   = ex_valid_q;
    opcode_d     = opcode_q;
    funct3_d     = funct3_q;
    funct7_d     = funct7_q;
    rs1_value_d  = rs1_value_q;
    mux_result_d = mux_result_q;
    rd_addr_d    = rd_addr_q;
    illegal_d    = illegal_q;
    if (accept_s) begin
      ex_valid_d   = 1'b1;
      opcode_d     = dec_opcode_s;
      funct3_d     = dec_funct3_s;
      funct7_d     = dec_funct7_s;
      rs1_value_d  = rs1_val_s;
      mux_result_d = dec_mux_s;
      rd_addr_d    = bus.instr_in[7 +: REG_ADDR_WIDTH];
      illegal_d    = dec_illegal_s;
    end else if (bus.ex_ready_in) begin
      ex_valid_d = 1'b0;
    end else begin
      ex_valid_d = ex_valid_q;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        rf_q[i] <= '0;
      end
      ex_valid_q   <= 1'b0;
      opcode_q     <= 7'd0;
      funct3_q     <= 3'd0;
      funct7_q     <= 7'd0;
      rs1_value_q  <= '0;
      mux_result_q <= '0;
      rd_addr_q    <= '0;
      illegal_q    <= 1'b0;
    end else begin
      rf_q         <= rf_d;
      ex_valid_q   <= ex_valid_d;
      opcode_q     <= opcode_d;
      funct3_q     <= funct3_d;
      funct7_q     <= funct7_d;
      rs1_value_q  <= rs1_value_d;
      mux_result_q <= mux_result_d;
      rd_addr_q    <= rd_addr_d;
      illegal_q    <= illegal_d;
    end
  end

  assign bus.instr_ready_out = ready_s;
  assign bus.ex_valid_out    = ex_valid_q;
  assign bus.opcode_out      = opcode_q;
  assign bus.funct3_out      = funct3_q;
  assign bus.funct7_out      = funct7_q;
  assign bus.rs1_value_out   = rs1_value_q;
  assign bus.mux_result_out  = mux_result_q;
  assign bus.rd_addr_out     = rd_addr_q;
  assign bus.illegal_out     = illegal_q;
endmodule
